// File: rtl/gng_noise_scaler_if.sv
// Sample-stream bundle for gng_noise_scaler: raw GNG samples in, scaled noise out.
// The slave modport is the scaler's view; the master modport is the producer/consumer side.
interface gng_noise_scaler_if #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned NBT_GNG   = 16,
    parameter int unsigned NBT_NOISE = 8,
    parameter int unsigned NBT_FRES  = 24
);
    logic                       i_valid;
    logic [N_CH*NBT_GNG-1:0]    i_gng;
    logic                       o_valid;
    logic [N_CH*NBT_NOISE-1:0]  o_noise;
    logic [N_CH*NBT_FRES-1:0]   o_noise_fres;

    modport master (
        output i_valid,
        output i_gng,
        input  o_valid,
        input  o_noise,
        input  o_noise_fres
    );

    modport slave (
        input  i_valid,
        input  i_gng,
        output o_valid,
        output o_noise,
        output o_noise_fres
    );
endinterface

// File: rtl/gng_noise_scaler.sv
// Two-stage multi-channel Gaussian noise scaler: multiply by a double-buffered sigma,
// then round half-up and saturate, counting beats in which any channel clamped.
module gng_noise_scaler #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned NBT_GNG   = 16,
    parameter int unsigned NBF_GNG   = 11,
    parameter int unsigned NBT_SIGMA = 8,
    parameter int unsigned NBF_SIGMA = 7,
    parameter int unsigned NBT_NOISE = 8,
    parameter int unsigned NBF_NOISE = 7,
    parameter int unsigned NB_CNT    = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    gng_noise_scaler_if.slave    bus_if,
    input  logic [NBT_SIGMA-1:0] i_sigma,
    input  logic                 i_sigma_load,
    input  logic                 i_clr_cnt,
    output logic [NBT_SIGMA-1:0] o_sigma_active,
    output logic                 o_sigma_pending,
    output logic [NB_CNT-1:0]    o_sat_cnt
);
    localparam int unsigned NBT_FRES = NBT_GNG + NBT_SIGMA;
    localparam int unsigned NBF_FRES = NBF_GNG + NBF_SIGMA;
    localparam int unsigned SH       = NBF_FRES - NBF_NOISE;

    localparam logic [NBT_NOISE-1:0] NOISE_MAX = {1'b0, {(NBT_NOISE-1){1'b1}}};
    localparam logic [NBT_NOISE-1:0] NOISE_MIN = {1'b1, {(NBT_NOISE-1){1'b0}}};
    localparam logic signed [NBT_FRES:0] RMAX =
        $signed({{(NBT_FRES+1-NBT_NOISE){1'b0}}, NOISE_MAX});
    localparam logic signed [NBT_FRES:0] RMIN =
        $signed({{(NBT_FRES+1-NBT_NOISE){1'b1}}, NOISE_MIN});
    localparam logic signed [NBT_FRES:0] RND = (NBT_FRES+1)'(1) << (SH-1);

    logic [NBT_SIGMA-1:0]           shadow_q, shadow_d;
    logic [NBT_SIGMA-1:0]           active_q, active_d;
    logic                           pending_q, pending_d;
    logic                           v1_q, v1_d;
    logic signed [NBT_FRES-1:0]     p_q [N_CH];
    logic signed [NBT_FRES-1:0]     p_d [N_CH];
    logic                           valid_q, valid_d;
    logic [N_CH*NBT_NOISE-1:0]      noise_q, noise_d;
    logic [N_CH*NBT_FRES-1:0]       fres_q, fres_d;
    logic [NB_CNT-1:0]              cnt_q, cnt_d;
    logic                           sat_any;

    // Apply only on a gap cycle so a burst never sees two sigmas; a concurrent
    // load lands in the shadow after the old shadow has moved to active.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (pending_q && !bus_if.i_valid) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (i_sigma_load) begin
            shadow_d  = i_sigma;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        v1_d = bus_if.i_valid;
        for (int k = 0; k < N_CH; k++) begin
            p_d[k] = $signed({{NBT_SIGMA{bus_if.i_gng[k*NBT_GNG+NBT_GNG-1]}},
                              bus_if.i_gng[k*NBT_GNG +: NBT_GNG]})
                   * $signed({{NBT_GNG{active_q[NBT_SIGMA-1]}}, active_q});
        end
    end

    always_comb begin
        logic signed [NBT_FRES:0] rnd;
        rnd     = '0;
        noise_d = '0;
        fres_d  = '0;
        sat_any = 1'b0;
        valid_d = v1_q;
        for (int k = 0; k < N_CH; k++) begin
            // One extra bit so adding the half-LSB can never wrap.
            rnd = ($signed({p_q[k][NBT_FRES-1], p_q[k]}) + RND) >>> SH;
            fres_d[k*NBT_FRES +: NBT_FRES] = p_q[k];
            if (rnd > RMAX) begin
                noise_d[k*NBT_NOISE +: NBT_NOISE] = NOISE_MAX;
                sat_any = 1'b1;
            end else if (rnd < RMIN) begin
                noise_d[k*NBT_NOISE +: NBT_NOISE] = NOISE_MIN;
                sat_any = 1'b1;
            end else begin
                noise_d[k*NBT_NOISE +: NBT_NOISE] = rnd[NBT_NOISE-1:0];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if (v1_q && sat_any && (cnt_q != {NB_CNT{1'b1}})) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            v1_q      <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                p_q[k] <= '0;
            end
            valid_q   <= 1'b0;
            noise_q   <= '0;
            fres_q    <= '0;
            cnt_q     <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            v1_q      <= v1_d;
            for (int k = 0; k < N_CH; k++) begin
                p_q[k] <= p_d[k];
            end
            valid_q   <= valid_d;
            noise_q   <= noise_d;
            fres_q    <= fres_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus_if.o_valid      = valid_q;
    assign bus_if.o_noise      = noise_q;
    assign bus_if.o_noise_fres = fres_q;
    assign o_sigma_active      = active_q;
    assign o_sigma_pending     = pending_q;
    assign o_sat_cnt           = cnt_q;
endmodule

// File: tb/tb_gng_noise_scaler.sv
// Scoreboard bench for gng_noise_scaler: expected beats are queued at drive time and
// popped when o_valid appears; a second instance with a 4-bit counter checks clamping.
module tb_gng_noise_scaler;
    localparam int N_CH      = 2;
    localparam int NBT_GNG   = 16;
    localparam int NBT_NOISE = 8;
    localparam int NBT_FRES  = 24;
    localparam int SH        = 11;

    typedef struct {
        logic [N_CH*NBT_NOISE-1:0] noise;
        logic [N_CH*NBT_FRES-1:0]  fres;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sigma;
    logic       sigma_load;
    logic       clr_cnt;
    logic [7:0] sig_act, sig_act4;
    logic       pend, pend4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   m_shadow, m_active;
    bit   m_pend;

    always #5 clk = ~clk;

    gng_noise_scaler_if #(.N_CH(N_CH), .NBT_GNG(NBT_GNG), .NBT_NOISE(NBT_NOISE),
                          .NBT_FRES(NBT_FRES)) bus ();
    gng_noise_scaler_if #(.N_CH(N_CH), .NBT_GNG(NBT_GNG), .NBT_NOISE(NBT_NOISE),
                          .NBT_FRES(NBT_FRES)) bus4 ();

    assign bus4.i_valid = bus.i_valid;
    assign bus4.i_gng   = bus.i_gng;

    gng_noise_scaler dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .bus_if         (bus.slave),
        .i_sigma        (sigma),
        .i_sigma_load   (sigma_load),
        .i_clr_cnt      (clr_cnt),
        .o_sigma_active (sig_act),
        .o_sigma_pending(pend),
        .o_sat_cnt      (cnt)
    );

    gng_noise_scaler #(.NB_CNT(4)) dut4 (
        .i_clock        (clk),
        .i_reset        (rst),
        .bus_if         (bus4.slave),
        .i_sigma        (sigma),
        .i_sigma_load   (sigma_load),
        .i_clr_cnt      (clr_cnt),
        .o_sigma_active (sig_act4),
        .o_sigma_pending(pend4),
        .o_sat_cnt      (cnt4)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model_beat(input int g0, input int g1, input int s);
        exp_t   e;
        longint p, r;
        int     g[2];
        g[0] = g0;
        g[1] = g1;
        for (int k = 0; k < N_CH; k++) begin
            p = longint'(g[k]) * longint'(s);
            r = (p + (64'sd1 <<< (SH-1))) >>> SH;
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            e.noise[k*NBT_NOISE +: NBT_NOISE] = 8'(r);
            e.fres[k*NBT_FRES +: NBT_FRES]    = 24'(p);
        end
        return e;
    endfunction

    // Drive one cycle at the falling edge and advance the spec-level sigma model.
    task automatic drive(input bit v, input int g0, input int g1, input bit ld, input int s,
                         input bit clr);
        bus.i_valid = v;
        bus.i_gng   = {16'(g1), 16'(g0)};
        sigma_load  = ld;
        sigma       = 8'(s);
        clr_cnt     = clr;
        if (v) q.push_back(model_beat(g0, g1, m_active));
        if (m_pend && !v) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        if (ld) begin
            m_shadow = s;
            m_pend   = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset(input bit v);
        rst         = 1'b1;
        bus.i_valid = v;
        bus.i_gng   = {16'(-2048), 16'(2048)};
        sigma_load  = 1'b1;
        sigma       = 8'd100;
        clr_cnt     = 1'b0;
        q.delete();
        m_shadow = 0;
        m_active = 0;
        m_pend   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_valid) begin
                check_eq("valid_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check_eq("noise", 64'(bus.o_noise), 64'(e.noise));
                    check_eq("noise_fres", 64'(bus.o_noise_fres), 64'(e.fres));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_gng   = '0;
        sigma       = '0;
        sigma_load  = 1'b0;
        clr_cnt     = 1'b0;
        m_shadow    = 0;
        m_active    = 0;
        m_pend      = 1'b0;
        fork
            monitor();
        join_none
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", 64'(bus.o_valid), 64'd0);
        check_eq("rst_noise", 64'(bus.o_noise), 64'd0);
        check_eq("rst_fres", 64'(bus.o_noise_fres), 64'd0);
        check_eq("rst_cnt", 64'(cnt), 64'd0);
        check_eq("rst_pending", 64'(pend), 64'd0);
        check_eq("rst_active", 64'(sig_act), 64'd0);

        // Nominal scaling and rounding at sigma = 0.5
        drive(1'b0, 0, 0, 1'b1, 64, 1'b0);
        check_eq("load_pending", 64'(pend), 64'd1);
        idle(1);
        check_eq("apply_pending", 64'(pend), 64'd0);
        check_eq("apply_active", 64'(sig_act), 64'd64);
        drive(1'b1, 2048, -2048, 1'b0, 0, 1'b0);
        drive(1'b1, 16, -16, 1'b0, 0, 1'b0);
        drive(1'b1, 15, -17, 1'b0, 0, 1'b0);
        idle(3);
        check_eq("nominal_cnt", 64'(cnt), 64'd0);

        // Saturation at sigma = 0.75, then clear racing an increment
        drive(1'b0, 0, 0, 1'b1, 96, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) drive(1'b1, 4096, -4096, 1'b0, 0, 1'b0);
        idle(2);
        check_eq("sat_cnt4", 64'(cnt), 64'd4);
        drive(1'b1, 4096, -4096, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle(1);
        check_eq("clr_priority", 64'(cnt), 64'd0);

        // Double-buffered sigma across a 10-beat burst
        drive(1'b0, 0, 0, 1'b1, 64, 1'b0);
        idle(1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2048, -2048, (i == 3), 32, 1'b0);
            if (i >= 3) check_eq("burst_pending", 64'(pend), 64'd1);
        end
        check_eq("burst_active_held", 64'(sig_act), 64'd64);
        idle(1);
        check_eq("gap_pending", 64'(pend), 64'd0);
        check_eq("gap_active", 64'(sig_act), 64'd32);
        for (int i = 0; i < 3; i++) drive(1'b1, 2048, -2048, 1'b0, 0, 1'b0);
        idle(3);

        // Counter clamping: 20 saturating beats
        drive(1'b0, 0, 0, 1'b1, 96, 1'b0);
        idle(1);
        for (int i = 0; i < 20; i++) drive(1'b1, 4096, -4096, 1'b0, 0, 1'b0);
        idle(2);
        check_eq("cnt16_20", 64'(cnt), 64'd20);
        check_eq("cnt4_hold", 64'(cnt4), 64'd15);

        // Reset mid-burst drops in-flight beats and silences the output
        drive(1'b0, 0, 0, 1'b1, 64, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1'b1, 2048, -2048, 1'b0, 0, 1'b0);
        do_reset(1'b1);
        check_eq("mid_rst_valid0", 64'(bus.o_valid), 64'd0);
        check_eq("mid_rst_noise", 64'(bus.o_noise), 64'd0);
        check_eq("mid_rst_fres", 64'(bus.o_noise_fres), 64'd0);
        check_eq("mid_rst_active", 64'(sig_act), 64'd0);
        check_eq("mid_rst_pending", 64'(pend), 64'd0);
        check_eq("mid_rst_cnt", 64'(cnt), 64'd0);
        idle(1);
        check_eq("mid_rst_valid1", 64'(bus.o_valid), 64'd0);
        drive(1'b1, 2048, -2048, 1'b0, 0, 1'b0);
        drive(1'b1, 4096, -4096, 1'b0, 0, 1'b0);
        idle(3);

        // Random samples once sigma is reloaded
        drive(1'b0, 0, 0, 1'b1, 64, 1'b0);
        idle(1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, int'($signed(16'($urandom_range(0, 65535)))),
                  int'($signed(16'($urandom_range(0, 65535)))), 1'b0, 0, 1'b0);
        end
        idle(4);
        check_eq("drain", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
